// File: rtl/rs_dec_pkg.sv
// Shared GF(2^m) arithmetic, basis conversion and types for the RS decoder front end.
// Field helpers operate on a fixed 16-bit container; callers truncate to MM.
package rs_dec_pkg;

  localparam int GF_W   = 16;
  localparam int DEF_TT = 16;
  localparam int NSYND  = 2 * DEF_TT;

  typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} in_state_e;

  // Rows of the dual-to-conventional matrix; row i is selected by dual bit z_i (z_0 = MSB).
  localparam logic [7:0] D2C_ROWS [8] = '{8'hC5, 8'h42, 8'h2E, 8'hFD,
                                          8'hF0, 8'h79, 8'hAC, 8'hCC};

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic logic [GF_W-1:0] gf_mul(input logic [GF_W-1:0] a,
                                             input logic [GF_W-1:0] b,
                                             input int mm,
                                             input logic [31:0] poly);
    logic [GF_W-1:0] r, x, mask, p;
    mask = GF_W'((32'd1 << mm) - 32'd1);
    p    = poly[GF_W-1:0];
    r    = '0;
    x    = a & mask;
    for (int i = 0; i < GF_W; i++) begin
      if (i < mm) begin
        if (b[i]) r ^= x;
        x = x[mm-1] ? (((x << 1) ^ p) & mask) : ((x << 1) & mask);
      end
    end
    return r;
  endfunction

  // alpha^e with the exponent reduced modulo the multiplicative group order.
  function automatic logic [GF_W-1:0] gf_pow(input int e, input int mm,
                                             input logic [31:0] poly);
    int n, em;
    logic [GF_W-1:0] r;
    n  = (1 << mm) - 1;
    em = e % n;
    r  = GF_W'(1);
    for (int i = 0; i < em; i++) r = gf_mul(r, GF_W'(2), mm, poly);
    return r;
  endfunction

  function automatic logic [7:0] dual_to_conv(input logic [7:0] d);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (d[7-i]) r ^= D2C_ROWS[i];
    return r;
  endfunction

endpackage

// File: rtl/rs_dec_synd_cell.sv
// One Horner syndrome cell: S <= (clr ? 0 : S*ROOT) ^ din, with the next value exposed
// so the parent can snapshot the final syndrome on the same edge it is formed.
module rs_dec_synd_cell
  import rs_dec_pkg::*;
#(
  parameter int             MM        = 8,
  parameter logic [MM-1:0]  ROOT      = '0,
  parameter logic [MM:0]    PRIM_POLY = 9'h187
) (
  input  logic          clk,
  input  logic          nGrst,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [MM-1:0] din,
  output logic [MM-1:0] s_nx
);

  logic [MM-1:0] s;

  assign s_nx = (clr ? '0 : MM'(gf_mul(GF_W'(s), GF_W'(ROOT), MM, 32'(PRIM_POLY)))) ^ din;

  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst)   s <= '0;
    else if (rst) s <= '0;
    else if (en)  s <= s_nx;
  end

endmodule

// File: rtl/rs_dec_syndrome_chk.sv
// Serial RS syndrome checker: accumulates 2*TT Horner syndromes per codeword, snapshots
// them into a shadow bank and unloads serially while the next word streams in.
module rs_dec_syndrome_chk
  import rs_dec_pkg::*;
#(
  parameter int          MM        = 8,
  parameter int          NN        = 255,
  parameter int          TT        = 16,
  parameter logic [MM:0] PRIM_POLY = 9'h187,
  parameter int          FCR       = 112,
  parameter int          GSTEP     = 11,
  parameter int          CCSDS     = 1
) (
  input  logic                      clk,
  input  logic                      nGrst,
  input  logic                      rst,
  input  logic                      clkEn,
  input  logic                      start,
  input  logic [MM-1:0]             dInp,
  output logic                      rfs,
  output logic                      rfd,
  output logic [MM-1:0]             synd,
  output logic [clog2(2*TT)-1:0]    syndIdx,
  output logic                      syndValid,
  output logic                      errDet,
  output logic                      done
);

  localparam int NS = 2 * TT;
  localparam int IW = clog2(NS);
  localparam int CW = clog2(NN);

  in_state_e state, state_nx;
  logic [CW-1:0] cnt;
  logic          last_sym, accept;

  assign last_sym = (cnt == CW'(NN - 1));
  assign accept   = clkEn & start & rfs;

  // Input FSM
  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst)   state <= S_IDLE;
    else if (rst) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = S_ACC;
      S_ACC:  if (clkEn && last_sym && !accept) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    rfd = (state == S_ACC);
    rfs = (state == S_IDLE) | ((state == S_ACC) & last_sym);
  end

  // A start on the last symbol restarts the count, giving gapless words.
  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst)                        cnt <= '0;
    else if (rst)                      cnt <= '0;
    else if (clkEn && state == S_ACC)  cnt <= last_sym ? '0 : cnt + CW'(1);
  end

  // Registered front end; the control flags ride alongside the data.
  logic [MM-1:0] din_cv, din_q;
  logic          rfd_d, first_d, last_d;

  if (CCSDS != 0) begin : g_dual
    assign din_cv = MM'(dual_to_conv(8'(dInp)));
  end else begin : g_conv
    assign din_cv = dInp;
  end

  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      din_q <= '0; rfd_d <= 1'b0; first_d <= 1'b0; last_d <= 1'b0;
    end else if (rst) begin
      din_q <= '0; rfd_d <= 1'b0; first_d <= 1'b0; last_d <= 1'b0;
    end else if (clkEn) begin
      din_q   <= din_cv;
      rfd_d   <= rfd;
      first_d <= rfd & (cnt == '0);
      last_d  <= rfd & last_sym;
    end
  end

  logic [NS-1:0][MM-1:0] s_nx;

  for (genvar j = 0; j < NS; j++) begin : g_cell
    localparam logic [MM-1:0] ROOT = MM'(gf_pow(GSTEP * (FCR + j), MM, 32'(PRIM_POLY)));
    rs_dec_synd_cell #(
      .MM        (MM),
      .ROOT      (ROOT),
      .PRIM_POLY (PRIM_POLY)
    ) u_cell (
      .clk   (clk),
      .nGrst (nGrst),
      .rst   (rst),
      .en    (clkEn & rfd_d),
      .clr   (first_d),
      .din   (din_q),
      .s_nx  (s_nx[j])
    );
  end

  // Shadow bank and serial unload; a fresh snapshot overrides the unload bookkeeping.
  logic [NS-1:0][MM-1:0] shadow;
  logic                  unl_act, err_pend;
  logic [IW-1:0]         ucnt;

  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      shadow <= '0; unl_act <= 1'b0; ucnt <= '0; err_pend <= 1'b0;
    end else if (rst) begin
      shadow <= '0; unl_act <= 1'b0; ucnt <= '0; err_pend <= 1'b0;
    end else if (clkEn) begin
      if (unl_act) begin
        if (ucnt == IW'(NS - 1)) begin
          unl_act <= 1'b0;
          ucnt    <= '0;
        end else begin
          ucnt <= ucnt + IW'(1);
        end
      end
      if (last_d) begin
        shadow   <= s_nx;
        unl_act  <= 1'b1;
        ucnt     <= '0;
        err_pend <= |s_nx;
      end
    end
  end

  always_comb begin
    syndValid = unl_act;
    syndIdx   = ucnt;
    synd      = unl_act ? shadow[ucnt] : '0;
    done      = unl_act & (ucnt == IW'(NS - 1));
    errDet    = done & err_pend;
  end

endmodule
